// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong match controller and its helpers.
package pong_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StServe,
        StPlay,
        StPoint,
        StOver
    } pong_state_t;

    localparam int unsigned SCORE_W       = 4;
    localparam int unsigned DEF_WIN_SCORE = 9;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pong_match_ctrl_if.sv
// Signal bundle between the playfield/button logic and the match controller.
interface pong_match_ctrl_if;
    import pong_pkg::*;

    logic               up;
    logic               down;
    logic               up1;
    logic               down1;
    logic               frame_tick;
    logic               miss_left;
    logic               miss_right;
    logic [SCORE_W-1:0] score1;
    logic [SCORE_W-1:0] score2;
    logic               start;
    logic               game_over;
    logic               play_en;
    logic               ball_reset;
    logic               serve_dir;

    modport master (
        output up, down, up1, down1, frame_tick, miss_left, miss_right,
        input  score1, score2, start, game_over, play_en, ball_reset, serve_dir
    );

    modport slave (
        input  up, down, up1, down1, frame_tick, miss_left, miss_right,
        output score1, score2, start, game_over, play_en, ball_reset, serve_dir
    );

endinterface

// File: rtl/pong_frame_timer.sv
// Counts frame ticks since the last clear and flags the tick that reaches the target count.
module pong_frame_timer #(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk_100MHz,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             en,
    input  logic             frame_tick,
    input  logic [CNT_W-1:0] target,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear wins over a coincident tick so the entry-edge tick is never counted.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (en && frame_tick) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = en && frame_tick && (cnt_q == (target - CNT_W'(1)));

endmodule

// File: rtl/pong_match_ctrl.sv
// Match-level FSM for two-player Pong: scoring, serve timing and ball-motion gating.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE    = DEF_WIN_SCORE,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned POINT_FRAMES = 30
) (
    input  logic              clk_100MHz,
    input  logic              reset_n,
    pong_match_ctrl_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(max_u(SERVE_FRAMES, POINT_FRAMES) + 1);

    localparam logic [SCORE_W-1:0] WIN     = SCORE_W'(WIN_SCORE);
    localparam logic [CNT_W-1:0]   SERVE_T = CNT_W'(SERVE_FRAMES);
    localparam logic [CNT_W-1:0]   POINT_T = CNT_W'(POINT_FRAMES);

    pong_state_t        state_q, state_d;
    logic [SCORE_W-1:0] score1_q, score1_d;
    logic [SCORE_W-1:0] score2_q, score2_d;
    logic               serve_dir_q, serve_dir_d;
    logic               ball_reset_q, ball_reset_d;
    logic               btn_prev_q;

    logic               any_btn;
    logic               press;
    logic               timer_clear;
    logic               timer_en;
    logic               timer_done;
    logic [CNT_W-1:0]   timer_target;

    assign any_btn = bus.up | bus.down | bus.up1 | bus.down1;
    assign press   = any_btn & ~btn_prev_q;

    pong_frame_timer #(
        .CNT_W (CNT_W)
    ) u_frame_timer (
        .clk_100MHz (clk_100MHz),
        .reset_n    (reset_n),
        .clear      (timer_clear),
        .en         (timer_en),
        .frame_tick (bus.frame_tick),
        .target     (timer_target),
        .done       (timer_done)
    );

    always_comb begin
        state_d      = state_q;
        score1_d     = score1_q;
        score2_d     = score2_q;
        serve_dir_d  = serve_dir_q;
        timer_target = SERVE_T;

        unique case (state_q)
            StIdle: begin
                if (press) begin
                    state_d = StServe;
                end
            end
            StServe: begin
                if (timer_done) begin
                    state_d = StPlay;
                end
            end
            StPlay: begin
                // A simultaneous double miss replays the point without scoring.
                if (bus.miss_left || bus.miss_right) begin
                    state_d = StPoint;
                end
                if (bus.miss_left && !bus.miss_right) begin
                    if (score2_q != WIN) begin
                        score2_d = score2_q + SCORE_W'(1);
                    end
                    serve_dir_d = 1'b0;
                end else if (bus.miss_right && !bus.miss_left) begin
                    if (score1_q != WIN) begin
                        score1_d = score1_q + SCORE_W'(1);
                    end
                    serve_dir_d = 1'b1;
                end
            end
            StPoint: begin
                timer_target = POINT_T;
                if (timer_done) begin
                    state_d = ((score1_q == WIN) || (score2_q == WIN)) ? StOver : StServe;
                end
            end
            StOver: begin
                if (press) begin
                    score1_d    = '0;
                    score2_d    = '0;
                    serve_dir_d = 1'b1;
                    state_d     = StServe;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign timer_clear  = (state_d != state_q);
    assign timer_en     = (state_q == StServe) || (state_q == StPoint);
    assign ball_reset_d = (state_d == StServe) && (state_q != StServe);

    // Previous-button register resets high so a button held through reset is not a press.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            score1_q     <= '0;
            score2_q     <= '0;
            serve_dir_q  <= 1'b1;
            ball_reset_q <= 1'b0;
            btn_prev_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            score1_q     <= score1_d;
            score2_q     <= score2_d;
            serve_dir_q  <= serve_dir_d;
            ball_reset_q <= ball_reset_d;
            btn_prev_q   <= any_btn;
        end
    end

    assign bus.score1     = score1_q;
    assign bus.score2     = score2_q;
    assign bus.start      = (state_q != StIdle);
    assign bus.game_over  = (state_q == StOver);
    assign bus.play_en    = (state_q == StPlay);
    assign bus.ball_reset = ball_reset_q;
    assign bus.serve_dir  = serve_dir_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench: dut_a (WIN_SCORE=2) covers match flow, dut_b (WIN_SCORE=9) the mid-play reset.
module tb_pong_match_ctrl;

    logic clk_100MHz;
    logic reset_n;
    logic up, down, up1, down1;
    logic frame_tick, miss_left, miss_right;

    int n_checks = 0;
    int n_fail   = 0;

    pong_match_ctrl_if bus_a ();
    pong_match_ctrl_if bus_b ();

    assign bus_a.up = up;   assign bus_a.down = down;   assign bus_a.up1 = up1;
    assign bus_a.down1 = down1;   assign bus_a.frame_tick = frame_tick;
    assign bus_a.miss_left = miss_left;   assign bus_a.miss_right = miss_right;
    assign bus_b.up = up;   assign bus_b.down = down;   assign bus_b.up1 = up1;
    assign bus_b.down1 = down1;   assign bus_b.frame_tick = frame_tick;
    assign bus_b.miss_left = miss_left;   assign bus_b.miss_right = miss_right;

    pong_match_ctrl #(
        .WIN_SCORE    (2),
        .SERVE_FRAMES (3),
        .POINT_FRAMES (2)
    ) dut_a (
        .clk_100MHz (clk_100MHz),
        .reset_n    (reset_n),
        .bus        (bus_a)
    );

    pong_match_ctrl #(
        .WIN_SCORE    (9),
        .SERVE_FRAMES (3),
        .POINT_FRAMES (2)
    ) dut_b (
        .clk_100MHz (clk_100MHz),
        .reset_n    (reset_n),
        .bus        (bus_b)
    );

    initial begin
        clk_100MHz = 1'b0;
        forever #5 clk_100MHz = ~clk_100MHz;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance n clock edges and settle 1 time unit past the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk_100MHz);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
        cyc(1);
    endtask

    task automatic miss(input logic l, input logic r);
        miss_left  = l;
        miss_right = r;
        cyc(1);
        miss_left  = 1'b0;
        miss_right = 1'b0;
    endtask

    initial begin
        logic found;
        {up, down, up1, down1} = 4'b1000;
        {frame_tick, miss_left, miss_right} = 3'b000;
        reset_n = 1'b0;
        cyc(2);
        check_val("rst_start", bus_a.start, 0);
        check_val("rst_serve_dir", bus_a.serve_dir, 1);
        reset_n = 1'b1;
        cyc(3);
        check_val("held_btn_idle", bus_a.start, 0);
        check_val("held_btn_ball_reset", bus_a.ball_reset, 0);

        // Release and re-press starts the match.
        up = 1'b0;
        cyc(2);
        up = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc(1);
            if (bus_a.ball_reset) begin
                found = 1'b1;
                break;
            end
        end
        check_val("press_ball_reset", found, 1);
        check_val("press_start", bus_a.start, 1);
        cyc(1);
        check_val("ball_reset_width", bus_a.ball_reset, 0);
        up = 1'b0;

        // Serve: play_en rises on the edge sampling the 3rd tick.
        tick();
        tick();
        check_val("serve_before_3rd", bus_a.play_en, 0);
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
        check_val("serve_3rd_tick", bus_a.play_en, 1);

        miss(1'b1, 1'b0);
        check_val("ml_score2", bus_a.score2, 1);
        check_val("ml_score1", bus_a.score1, 0);
        check_val("ml_serve_dir", bus_a.serve_dir, 0);
        check_val("ml_play_en", bus_a.play_en, 0);

        tick();
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
        check_val("point_to_serve", bus_a.ball_reset, 1);
        cyc(1);
        tick(); tick(); tick();
        check_val("replay_in_play", bus_a.play_en, 1);

        // Double miss replays the point; misses during POINT are ignored.
        miss(1'b1, 1'b1);
        check_val("dbl_score1", bus_a.score1, 0);
        check_val("dbl_score2", bus_a.score2, 1);
        check_val("dbl_serve_dir", bus_a.serve_dir, 0);
        check_val("dbl_play_en", bus_a.play_en, 0);
        check_val("dbl_start", bus_a.start, 1);
        miss(1'b0, 1'b1);
        check_val("point_miss_ignored", bus_a.score1, 0);

        tick(); tick();
        tick(); tick(); tick();
        miss(1'b0, 1'b1);
        check_val("mr1_score1", bus_a.score1, 1);
        check_val("mr1_serve_dir", bus_a.serve_dir, 1);
        tick(); tick();
        tick(); tick(); tick();
        miss(1'b0, 1'b1);
        check_val("mr2_score1", bus_a.score1, 2);
        tick();
        frame_tick = 1'b1;
        cyc(1);
        frame_tick = 1'b0;
        check_val("win_game_over", bus_a.game_over, 1);
        check_val("win_play_en", bus_a.play_en, 0);
        check_val("nowin_b_game_over", bus_b.game_over, 0);
        check_val("nowin_b_ball_reset", bus_b.ball_reset, 1);

        miss(1'b1, 1'b0);
        check_val("over_miss_s1", bus_a.score1, 2);
        check_val("over_miss_s2", bus_a.score2, 1);

        // Restart from OVER with a tick on the entry edge, which must not count.
        down1 = 1'b1;
        frame_tick = 1'b1;
        cyc(1);
        down1 = 1'b0;
        frame_tick = 1'b0;
        check_val("restart_ball_reset", bus_a.ball_reset, 1);
        check_val("restart_game_over", bus_a.game_over, 0);
        check_val("restart_score1", bus_a.score1, 0);
        check_val("restart_score2", bus_a.score2, 0);
        check_val("restart_serve_dir", bus_a.serve_dir, 1);
        tick(); tick();
        check_val("entry_tick_not_counted", bus_a.play_en, 0);
        tick();
        check_val("restart_play", bus_a.play_en, 1);

        reset_n = 1'b0;
        cyc(1);
        reset_n = 1'b1;
        cyc(1);
        check_val("rst2_b_start", bus_b.start, 0);
        check_val("rst2_b_score1", bus_b.score1, 0);

        // Bring dut_b to 5/3 in PLAY, then reset between edges.
        up1 = 1'b1;
        cyc(1);
        up1 = 1'b0;
        cyc(1);
        for (int i = 0; i < 8; i++) begin
            tick(); tick(); tick();
            if (i < 5) miss(1'b0, 1'b1);
            else       miss(1'b1, 1'b0);
            tick(); tick();
        end
        tick(); tick(); tick();
        check_val("pre_rst_score1", bus_b.score1, 5);
        check_val("pre_rst_score2", bus_b.score2, 3);
        check_val("pre_rst_play_en", bus_b.play_en, 1);
        #3;
        reset_n = 1'b0;
        #1;
        check_val("async_score1", bus_b.score1, 0);
        check_val("async_score2", bus_b.score2, 0);
        check_val("async_start", bus_b.start, 0);
        check_val("async_play_en", bus_b.play_en, 0);
        check_val("async_game_over", bus_b.game_over, 0);
        check_val("async_ball_reset", bus_b.ball_reset, 0);
        check_val("async_serve_dir", bus_b.serve_dir, 1);
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
